exec_writeback: RTL and testbench
=================================

// Module: exec_writeback
// PURPOSE
//  Execute->writeback stage of the 8-bit CPU. Selects the result and flags of the issuing execution
//  unit (adder, logic, signed multiplier, pass), buffers them in a 2-entry skid FIFO, then commits in order.
//  Each commit writes the register file and merges flags into the architectural flag register.
//  Decouples combinational execution units from register-file write stalls.
// PARAMETERS
//  NUM_UNITS   4   execution units on the result/flag buses (unit_sel width fixed at 2)
//  DATA_W      8   result width
//  RADDR_W     2   register address width (4 GPRs)
// PORTS
//  clk          in   1                    rising-edge clock
//  rst          in   1                    synchronous reset, active-high
//  ex_valid     in   1                    execute slot holds an instruction
//  ex_ready     out  1                    stage accepts; transfer = ex_valid & ex_ready
//  ex_unit_sel  in   2                    unit producing the result
//  ex_res_bus   in   NUM_UNITS*DATA_W     unit results, unit k at [k*8 +: 8]
//  ex_flags_bus in   NUM_UNITS*8          unit flags {4'b0,NF,OF,CF,ZF}, unit k at [k*8 +: 8]
//  ex_rd        in   RADDR_W              destination register
//  ex_wen       in   1                    instruction writes ex_rd
//  ex_fmask     in   4                    flag update mask, bit order {NF,OF,CF,ZF}
//  wb_valid     out  1                    head entry present
//  wb_ready     in   1                    regfile accepts; commit = wb_valid & wb_ready
//  wb_we        out  1                    head entry's wen (regfile writes only on commit)
//  wb_rd        out  RADDR_W              head destination
//  wb_data      out  DATA_W               head result
//  flags_q      out  8                    architectural flags {4'b0,NF,OF,CF,ZF}
//  rs_addr      in   RADDR_W              bypass lookup address (FWD_BYPASS_EN)
//  rs_hit       out  1                    bypass hit
//  rs_data      out  DATA_W               bypass data
// BEHAVIOUR
//  - Reset: count=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, flags_q=8'h00, ex_ready=1; in-flight entries dropped.
//  - Capture on transfer: result/flags = bus slice ex_unit_sel; unit_sel>=NUM_UNITS -> result 0, flags 8'h01.
//  - Entry = {rd, wen, fmask, result, flags[3:0]}; FIFO depth 2, count 0..2, in-order.
//  - ex_ready = (count!=2); registered from count, no combinational path from wb_ready.
//  - Head outputs registered; wb_valid=(count!=0); wb_* hold steady while wb_valid & !wb_ready.
//  - Empty + transfer: entry visible on wb_* next cycle (1-cycle latency).
//  - Push and commit same cycle: count unchanged; new entry becomes head only if it is the sole remaining entry.
//  - Full (count=2): ex_ready=0 even if wb_ready=1 this cycle (no same-cycle push on full).
//  - Commit: flags_q[3:0] <= (flags_q[3:0] & ~fmask) | (eflags & fmask); flags_q[7:4] always 0.
//  - fmask=0 commits leave flags_q unchanged; wen=0 entries still commit (flags-only ops, e.g. CMP).
//  - flags_q visible the cycle after commit; no flag forwarding.
//  - No arithmetic here; results/flags pass through unmodified (multiplier sign-magnitude format preserved).
// CONFIGURATION
//  FWD_BYPASS_EN defined: rs_hit=1 when any buffered entry has wen=1 and rd==rs_addr;
//    rs_data = youngest such entry (tail over head); purely combinational from FIFO state.
//  Undefined: rs_hit=0, rs_data=0; ports remain; rs_addr ignored.
// STRUCTURE
//  cpu_pkg: DATA_W, RADDR_W, flag bit indices (ZF=0,CF=1,OF=2,NF=3), unit codes
//    UNIT_ADD=0, UNIT_LOGIC=1, UNIT_MUL=2, UNIT_PASS=3, entry struct/width constant.
//  Sub-module: wb_skid_fifo (2-entry, parameterized entry width, count, in-order);
//    top does unit select, flag merge, bypass search.
// TESTING
//  1 Mul commit: sel=2, res 8'h86, flags 8'h08, rd=1, wen=1, fmask=F, wb_ready=1
//    -> next cycle wb_valid=1, wb_data=86, wb_rd=1; cycle after, flags_q=08.
//  2 Masked flags: flags_q=08, commit flags 8'h01, fmask=4'b0001 -> flags_q=09.
//  3 Backpressure: wb_ready=0, push 11,22 -> ex_ready=0 after 2nd;
//    third push held; wb_ready=1 -> commits 11,22,33 in order, no loss/dup.
//  4 Simultaneous push/commit at count=1 for 8 cycles -> count stays 1, one commit per cycle, data in order.
//  5 Invalid sel=3 with NUM_UNITS=3 -> wb_data=00, flags_q ZF=1 (fmask=F).
//  6 Reset with count=2 and wb_ready=0 -> next cycle wb_valid=0, flags_q=00, ex_ready=1;
//    with FWD_BYPASS_EN, rd=2 entries 44 then 55 -> rs_addr=2 gives hit=1, data=55.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU execute/writeback path.
// Holds the writeback entry layout and the flag-merge helper.
package cpu_pkg;

    localparam int DATA_W  = 8;
    localparam int RADDR_W = 2;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NF = 3;

    localparam logic [1:0] UNIT_ADD   = 2'd0;
    localparam logic [1:0] UNIT_LOGIC = 2'd1;
    localparam logic [1:0] UNIT_MUL   = 2'd2;
    localparam logic [1:0] UNIT_PASS  = 2'd3;

    // Flags returned for a unit select that names no real unit: ZF only.
    localparam logic [7:0] BAD_UNIT_FLAGS = 8'h01;

    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic               wen;
        logic [3:0]         fmask;
        logic [DATA_W-1:0]  result;
        logic [3:0]         flags;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                               input logic [3:0] upd,
                                               input logic [3:0] mask);
        return (cur & ~mask) | (upd & mask);
    endfunction

endpackage

// File: rtl/exec_writeback_if.sv
// Execute-side, writeback-side and bypass signals of exec_writeback.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1; valid never waits on ready.
interface exec_writeback_if #(
    parameter int NUM_UNITS = 4
);
    import cpu_pkg::*;

    logic                          ex_valid;
    logic                          ex_ready;
    logic [1:0]                    ex_unit_sel;
    logic [NUM_UNITS*DATA_W-1:0]   ex_res_bus;
    logic [NUM_UNITS*8-1:0]        ex_flags_bus;
    logic [RADDR_W-1:0]            ex_rd;
    logic                          ex_wen;
    logic [3:0]                    ex_fmask;

    logic                          wb_valid;
    logic                          wb_ready;
    logic                          wb_we;
    logic [RADDR_W-1:0]            wb_rd;
    logic [DATA_W-1:0]             wb_data;
    logic [7:0]                    flags_q;

    logic [RADDR_W-1:0]            rs_addr;
    logic                          rs_hit;
    logic [DATA_W-1:0]             rs_data;

    modport slave (
        input  ex_valid, ex_unit_sel, ex_res_bus, ex_flags_bus, ex_rd, ex_wen, ex_fmask,
        input  wb_ready, rs_addr,
        output ex_ready, wb_valid, wb_we, wb_rd, wb_data, flags_q, rs_hit, rs_data
    );

    modport master (
        output ex_valid, ex_unit_sel, ex_res_bus, ex_flags_bus, ex_rd, ex_wen, ex_fmask,
        output wb_ready, rs_addr,
        input  ex_ready, wb_valid, wb_we, wb_rd, wb_data, flags_q, rs_hit, rs_data
    );

endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order FIFO with a registered head; slot0 is always the head, slot1 the tail.
module wb_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] head_o,
    output logic [W-1:0] tail_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    // Ready depends only on stored occupancy, so a full FIFO refuses a push even while draining.
    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    slot0_d = in_data_i;
                end else begin
                    slot1_d = in_data_i;
                end
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                slot0_d = slot1_q;
                slot1_d = '0;
            end
            // Push and pop together only happen at count 1: the new entry replaces the head.
            2'b11: begin
                slot0_d = in_data_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign tail_o  = slot1_q;
    assign count_o = count_q;

endmodule

// File: rtl/exec_writeback.sv
// Execute->writeback stage: selects the issuing unit's result/flags, buffers them, commits in order.
// Define FWD_BYPASS_EN to enable the rs_addr lookup into buffered entries.
module exec_writeback
    import cpu_pkg::*;
#(
    parameter int NUM_UNITS = 4
) (
    input logic              clk,
    input logic              rst,
    exec_writeback_if.slave  ex_if
);

    logic [DATA_W-1:0]  sel_res;
    logic [7:0]         sel_flags;
    wb_entry_t          in_entry;
    wb_entry_t          head;
    wb_entry_t          tail;
    logic [ENTRY_W-1:0] head_bits;
    logic [ENTRY_W-1:0] tail_bits;
    logic [1:0]         fifo_count;
    logic               fifo_out_valid;
    logic               commit;
    logic [3:0]         flags_lo_q, flags_lo_d;

    always_comb begin
        sel_res   = '0;
        sel_flags = BAD_UNIT_FLAGS;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (int'(ex_if.ex_unit_sel) == k) begin
                sel_res   = ex_if.ex_res_bus[k*DATA_W +: DATA_W];
                sel_flags = ex_if.ex_flags_bus[k*8 +: 8];
            end
        end
    end

    always_comb begin
        in_entry        = '0;
        in_entry.rd     = ex_if.ex_rd;
        in_entry.wen    = ex_if.ex_wen;
        in_entry.fmask  = ex_if.ex_fmask;
        in_entry.result = sel_res;
        in_entry.flags  = sel_flags[3:0];
    end

    wb_skid_fifo #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (ex_if.ex_valid),
        .in_ready_o  (ex_if.ex_ready),
        .in_data_i   (in_entry),
        .out_valid_o (fifo_out_valid),
        .out_ready_i (ex_if.wb_ready),
        .head_o      (head_bits),
        .tail_o      (tail_bits),
        .count_o     (fifo_count)
    );

    assign head = wb_entry_t'(head_bits);
    assign tail = wb_entry_t'(tail_bits);

    assign commit         = fifo_out_valid & ex_if.wb_ready;
    assign ex_if.wb_valid = fifo_out_valid;
    assign ex_if.wb_we    = head.wen;
    assign ex_if.wb_rd    = head.rd;
    assign ex_if.wb_data  = head.result;

    // Architectural flags only change on commit, under the entry's own mask.
    always_comb begin
        flags_lo_d = flags_lo_q;
        if (commit) begin
            flags_lo_d = merge_flags(flags_lo_q, head.flags, head.fmask);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_lo_q <= 4'h0;
        end else begin
            flags_lo_q <= flags_lo_d;
        end
    end

    assign ex_if.flags_q = {4'b0000, flags_lo_q};

    logic unused_flags_hi;
    assign unused_flags_hi = ^sel_flags[7:4];

`ifdef FWD_BYPASS_EN
    logic hit_head, hit_tail;

    assign hit_head = (fifo_count != 2'd0) && head.wen && (head.rd == ex_if.rs_addr);
    assign hit_tail = (fifo_count == 2'd2) && tail.wen && (tail.rd == ex_if.rs_addr);

    // The tail is younger than the head, so it wins when both match.
    always_comb begin
        ex_if.rs_hit  = hit_head | hit_tail;
        ex_if.rs_data = '0;
        if (hit_tail) begin
            ex_if.rs_data = tail.result;
        end else if (hit_head) begin
            ex_if.rs_data = head.result;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = ^{ex_if.rs_addr, tail_bits, fifo_count};
    assign ex_if.rs_hit  = 1'b0;
    assign ex_if.rs_data = '0;
`endif

endmodule

// File: tb/tb_exec_writeback.sv
// Directed bench for exec_writeback: a 4-unit instance for most scenarios, a 3-unit one for invalid selects.
module tb_exec_writeback;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] commit_q[$];
  logic [7:0] exp_q[$];

  exec_writeback_if #(.NUM_UNITS(4)) bus4 ();
  exec_writeback_if #(.NUM_UNITS(3)) bus3 ();

  exec_writeback #(.NUM_UNITS(4)) dut4 (.clk(clk), .rst(rst), .ex_if(bus4));
  exec_writeback #(.NUM_UNITS(3)) dut3 (.clk(clk), .rst(rst), .ex_if(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Records every head value of dut4 that will commit on the coming edge.
  always @(negedge clk) begin
    if (!rst && bus4.wb_valid && bus4.wb_ready) commit_q.push_back(bus4.wb_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic drive4(input logic v, input logic [1:0] sel, input logic [7:0] res,
                        input logic [7:0] flg, input logic [1:0] rd, input logic wen,
                        input logic [3:0] fm);
    bus4.ex_valid = v;
    bus4.ex_unit_sel = sel;
    for (int k = 0; k < 4; k++) begin
      bus4.ex_res_bus[k*8 +: 8]   = (k == int'(sel)) ? res : ~res;
      bus4.ex_flags_bus[k*8 +: 8] = (k == int'(sel)) ? flg : ~flg;
    end
    bus4.ex_rd = rd;
    bus4.ex_wen = wen;
    bus4.ex_fmask = fm;
  endtask

  task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] res,
                        input logic [7:0] flg, input logic [1:0] rd, input logic wen,
                        input logic [3:0] fm);
    bus3.ex_valid = v;
    bus3.ex_unit_sel = sel;
    for (int k = 0; k < 3; k++) begin
      bus3.ex_res_bus[k*8 +: 8]   = (k == int'(sel)) ? res : ~res;
      bus3.ex_flags_bus[k*8 +: 8] = (k == int'(sel)) ? flg : ~flg;
    end
    bus3.ex_rd = rd;
    bus3.ex_wen = wen;
    bus3.ex_fmask = fm;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_tests++; if (bus4.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b exp 0", bus4.wb_valid); end
    n_tests++; if (bus4.wb_we !== 1'b0) begin n_fail++; $display("FAIL reset_wb_we got %b exp 0", bus4.wb_we); end
    n_tests++; if (bus4.wb_rd !== 2'd0) begin n_fail++; $display("FAIL reset_wb_rd got %h exp 0", bus4.wb_rd); end
    n_tests++; if (bus4.wb_data !== 8'h00) begin n_fail++; $display("FAIL reset_wb_data got %h exp 00", bus4.wb_data); end
    n_tests++; if (bus4.flags_q !== 8'h00) begin n_fail++; $display("FAIL reset_flags got %h exp 00", bus4.flags_q); end
    n_tests++; if (bus4.ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready got %b exp 1", bus4.ex_ready); end
    n_tests++; if (bus4.rs_hit !== 1'b0) begin n_fail++; $display("FAIL reset_rs_hit got %b exp 0", bus4.rs_hit); end
  endtask

  task automatic test_mul_commit();
    @(posedge clk); #1;
    bus4.wb_ready = 1'b1;
    drive4(1'b1, UNIT_MUL, 8'h86, 8'h08, 2'd1, 1'b1, 4'hF);
    @(posedge clk); #1;
    bus4.ex_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus4.wb_valid !== 1'b1) begin n_fail++; $display("FAIL mul_wb_valid got %b exp 1", bus4.wb_valid); end
    n_tests++; if (bus4.wb_data !== 8'h86) begin n_fail++; $display("FAIL mul_wb_data got %h exp 86", bus4.wb_data); end
    n_tests++; if (bus4.wb_rd !== 2'd1) begin n_fail++; $display("FAIL mul_wb_rd got %h exp 1", bus4.wb_rd); end
    n_tests++; if (bus4.wb_we !== 1'b1) begin n_fail++; $display("FAIL mul_wb_we got %b exp 1", bus4.wb_we); end
    n_tests++; if (bus4.flags_q !== 8'h00) begin n_fail++; $display("FAIL mul_flags_early got %h exp 00", bus4.flags_q); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus4.flags_q !== 8'h08) begin n_fail++; $display("FAIL mul_flags got %h exp 08", bus4.flags_q); end
    n_tests++; if (bus4.wb_valid !== 1'b0) begin n_fail++; $display("FAIL mul_drained got %b exp 0", bus4.wb_valid); end
  endtask

  task automatic test_masked_flags();
    @(posedge clk); #1;
    drive4(1'b1, UNIT_ADD, 8'h00, 8'h01, 2'd0, 1'b0, 4'b0001);
    @(posedge clk); #1;
    bus4.ex_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus4.wb_we !== 1'b0) begin n_fail++; $display("FAIL cmp_wb_we got %b exp 0", bus4.wb_we); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus4.flags_q !== 8'h09) begin n_fail++; $display("FAIL masked_flags got %h exp 09", bus4.flags_q); end
    @(posedge clk); #1;
    drive4(1'b1, UNIT_LOGIC, 8'hC3, 8'h0F, 2'd3, 1'b1, 4'b0000);
    @(posedge clk); #1;
    bus4.ex_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus4.wb_data !== 8'hC3) begin n_fail++; $display("FAIL logic_wb_data got %h exp c3", bus4.wb_data); end
    n_tests++; if (bus4.wb_rd !== 2'd3) begin n_fail++; $display("FAIL logic_wb_rd got %h exp 3", bus4.wb_rd); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus4.flags_q !== 8'h09) begin n_fail++; $display("FAIL zero_mask_flags got %h exp 09", bus4.flags_q); end
  endtask

  task automatic test_backpressure();
    commit_q.delete();
    exp_q = '{8'h11, 8'h22, 8'h33};
    @(posedge clk); #1;
    bus4.wb_ready = 1'b0;
    drive4(1'b1, UNIT_PASS, 8'h11, 8'h00, 2'd1, 1'b1, 4'h0);
    @(posedge clk); #1;
    drive4(1'b1, UNIT_PASS, 8'h22, 8'h00, 2'd2, 1'b1, 4'h0);
    @(posedge clk); #1;
    drive4(1'b1, UNIT_PASS, 8'h33, 8'h00, 2'd3, 1'b1, 4'h0);
    @(negedge clk);
    n_tests++; if (bus4.ex_ready !== 1'b0) begin n_fail++; $display("FAIL full_ex_ready got %b exp 0", bus4.ex_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus4.ex_ready !== 1'b0) begin n_fail++; $display("FAIL held_ex_ready got %b exp 0", bus4.ex_ready); end
    n_tests++; if (bus4.wb_data !== 8'h11) begin n_fail++; $display("FAIL held_wb_data got %h exp 11", bus4.wb_data); end
    n_tests++; if (bus4.wb_rd !== 2'd1) begin n_fail++; $display("FAIL held_wb_rd got %h exp 1", bus4.wb_rd); end
    @(posedge clk); #1;
    bus4.wb_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus4.ex_ready !== 1'b0) begin n_fail++; $display("FAIL full_drain_ex_ready got %b exp 0", bus4.ex_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus4.ex_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (commit_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_commit_count got %0d exp %0d", commit_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (commit_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_commit_%0d got %h exp %h", i, commit_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    commit_q.delete();
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'h40 + 8'(i));
    @(posedge clk); #1;
    bus4.wb_ready = 1'b0;
    drive4(1'b1, UNIT_ADD, 8'h40, 8'h00, 2'd0, 1'b1, 4'h0);
    @(posedge clk); #1;
    bus4.wb_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive4(1'b1, UNIT_ADD, 8'h40 + 8'(i), 8'h00, 2'(i), 1'b1, 4'h0);
      @(negedge clk);
      n_tests++; if (bus4.ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d got %b exp 1", i, bus4.ex_ready); end
      n_tests++; if (bus4.wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d got %b exp 1", i, bus4.wb_valid); end
      @(posedge clk); #1;
    end
    bus4.ex_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (commit_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_commit_count got %0d exp %0d", commit_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (commit_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_commit_%0d got %h exp %h", i, commit_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_invalid_sel();
    @(posedge clk); #1;
    bus3.wb_ready = 1'b1;
    drive3(1'b1, UNIT_PASS, 8'hA5, 8'h0E, 2'd2, 1'b1, 4'hF);
    @(posedge clk); #1;
    bus3.ex_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus3.wb_data !== 8'h00) begin n_fail++; $display("FAIL badsel_wb_data got %h exp 00", bus3.wb_data); end
    n_tests++; if (bus3.wb_rd !== 2'd2) begin n_fail++; $display("FAIL badsel_wb_rd got %h exp 2", bus3.wb_rd); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus3.flags_q !== 8'h01) begin n_fail++; $display("FAIL badsel_flags got %h exp 01", bus3.flags_q); end
    @(posedge clk); #1;
    drive3(1'b1, UNIT_LOGIC, 8'h5A, 8'h04, 2'd1, 1'b1, 4'hF);
    @(posedge clk); #1;
    bus3.ex_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus3.wb_data !== 8'h5A) begin n_fail++; $display("FAIL sel3_wb_data got %h exp 5a", bus3.wb_data); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus3.flags_q !== 8'h04) begin n_fail++; $display("FAIL sel3_flags got %h exp 04", bus3.flags_q); end
  endtask

  task automatic test_bypass_and_reset();
    @(posedge clk); #1;
    bus4.wb_ready = 1'b0;
    drive4(1'b1, UNIT_PASS, 8'h44, 8'h0F, 2'd2, 1'b1, 4'hF);
    @(posedge clk); #1;
    drive4(1'b1, UNIT_PASS, 8'h55, 8'h0F, 2'd2, 1'b1, 4'hF);
    @(posedge clk); #1;
    bus4.ex_valid = 1'b0;
    bus4.rs_addr = 2'd2;
    @(negedge clk);
`ifdef FWD_BYPASS_EN
    n_tests++; if (bus4.rs_hit !== 1'b1) begin n_fail++; $display("FAIL byp_hit got %b exp 1", bus4.rs_hit); end
    n_tests++; if (bus4.rs_data !== 8'h55) begin n_fail++; $display("FAIL byp_data got %h exp 55", bus4.rs_data); end
    bus4.rs_addr = 2'd1;
    #1;
    n_tests++; if (bus4.rs_hit !== 1'b0) begin n_fail++; $display("FAIL byp_miss got %b exp 0", bus4.rs_hit); end
`else
    n_tests++; if (bus4.rs_hit !== 1'b0) begin n_fail++; $display("FAIL byp_off_hit got %b exp 0", bus4.rs_hit); end
    n_tests++; if (bus4.rs_data !== 8'h00) begin n_fail++; $display("FAIL byp_off_data got %h exp 00", bus4.rs_data); end
`endif
    n_tests++; if (bus4.flags_q !== 8'h09) begin n_fail++; $display("FAIL pre_reset_flags got %h exp 09", bus4.flags_q); end
    n_tests++; if (bus4.ex_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_ready got %b exp 0", bus4.ex_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus4.rs_addr = 2'd2;
    @(negedge clk);
    n_tests++; if (bus4.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst2_wb_valid got %b exp 0", bus4.wb_valid); end
    n_tests++; if (bus4.flags_q !== 8'h00) begin n_fail++; $display("FAIL rst2_flags got %h exp 00", bus4.flags_q); end
    n_tests++; if (bus4.ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst2_ex_ready got %b exp 1", bus4.ex_ready); end
    n_tests++; if (bus4.wb_data !== 8'h00) begin n_fail++; $display("FAIL rst2_wb_data got %h exp 00", bus4.wb_data); end
    n_tests++; if (bus4.rs_hit !== 1'b0) begin n_fail++; $display("FAIL rst2_rs_hit got %b exp 0", bus4.rs_hit); end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    drive4(1'b0, UNIT_ADD, 8'h00, 8'h00, 2'd0, 1'b0, 4'h0);
    drive3(1'b0, UNIT_ADD, 8'h00, 8'h00, 2'd0, 1'b0, 4'h0);
    bus4.wb_ready = 1'b0;
    bus4.rs_addr = 2'd0;
    bus3.wb_ready = 1'b0;
    bus3.rs_addr = 2'd0;

    test_reset();
    test_mul_commit();
    test_masked_flags();
    test_backpressure();
    test_back_to_back();
    test_invalid_sel();
    test_bypass_and_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
